key_entry: RTL
==============

Name: key_entry

Overview:
Operand entry front end for the calculator, running in the input direction. The display path turns a binary result into BCD and then into segment codes; this block takes keypad codes, builds a signed BCD operand and converts it to an M-bit two's-complement value. The converted value is offered to the operand/ALU controller through a valid/ready handshake. The live BCD buffer is also exported so the display path can echo digits while the user types.

Parameters:
M, `OUTPUTWIDTH (32), output operand width in bits; static requirement: 10^MAX_DIGITS-1 < 2^(M-1)
MAX_DIGITS, 9, maximum number of decimal digits held
BCD_WIDTH, 4*MAX_DIGITS (36), width of the BCD buffer

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle strobe; key_code is valid in that cycle
key_code  in  4  0x0-0x9 digit, `KEY_SIGN (0xA), `KEY_CLR (0xB), `KEY_BKSP (0xC), `KEY_ENTER (0xD); 0xE/0xF are ignored
i_ready  in  1  consumer accepts o_val
o_val  out  M  signed two's-complement operand
o_valid  out  1  o_val is valid; held until accepted
o_busy  out  1  high in CONV and HOLD; keys are ignored while high
o_bcd  out  BCD_WIDTH  live digit buffer; digit 0 is in bits [3:0]
o_digits  out  4  count of stored digits, 0..MAX_DIGITS
o_neg  out  1  current sign flag
error  out  1  one-cycle pulse when a digit is rejected on overflow

Behaviour:
- Reset is asynchronous on the falling edge of RST_N. All outputs and internal registers go to 0 and the state goes to ENTRY. This holds in any state, including mid-CONV; no o_valid is produced for the aborted operation.
- Every state change and output change happens on the rising edge of CLK.
- States: ENTRY, CONV, HOLD.
- ENTRY handles one key per key_valid strobe:
  - Digit d:
    - count==0 and d==0: no change (leading zeros are not stored).
    - count<MAX_DIGITS: o_bcd <= {o_bcd[BCD_WIDTH-5:0], d} and count+1.
    - count==MAX_DIGITS: buffer and count unchanged; error pulses for one cycle.
  - SIGN: toggle o_neg. This is allowed at any count.
  - BKSP: o_bcd <= o_bcd>>4, count-1. At count 0 it is a no-op.
  - CLR: o_bcd, count and o_neg all go to 0.
  - ENTER: latch o_bcd and o_neg into the converter, then go to CONV; o_busy goes high in the next cycle.
- CONV uses reverse double-dabble, one shift per cycle, for exactly BCD_WIDTH cycles. Each cycle:
  - bin <= {bcd[0], bin[BCD_WIDTH-1:1]}, and the bcd register shifts right by 1.
  - Then every 4-bit BCD group that is >=8 has 3 subtracted from it.
  - After BCD_WIDTH cycles the magnitude is the low M-1 bits of bin.
  - If the latched sign is set and the magnitude is nonzero, o_val = -magnitude; otherwise o_val = magnitude. A zero result is never reported as negative.
- Latency: o_valid rises exactly BCD_WIDTH+1 cycles after the ENTER strobe cycle (37 for the defaults).
- HOLD: o_valid=1 and o_val is stable. In any cycle with o_valid && i_ready, the next edge does the following:
  - o_valid goes to 0 and the state goes to ENTRY.
  - o_bcd, count and o_neg are cleared, ready for the next operand.
  - o_val keeps its last value.
- Keys arriving in CONV or HOLD are dropped silently and do not raise error.
- ENTER with count 0 converts to o_val = 0, with the same latency as any other ENTER.

Decomposition:
- Key-code constants `KEY_SIGN, `KEY_CLR, `KEY_BKSP and `KEY_ENTER are added to define.v next to `OUTPUTWIDTH. No other shared typedefs are needed.
- One sub-module, bcd_to_bin, is natural. It is the reverse double-dabble core with ports i_ce, i_bcd, i_neg, o_val and done, and mirrors the result-to-BCD converter's start/done handshake.
- key_entry keeps the entry FSM, the digit buffer and the output handshake.

Test Plan:
- Keys 1,2,3,ENTER; i_ready=1 -> o_valid rises 37 cycles after the ENTER strobe, o_val=0x0000007B; one cycle later o_valid=0 and o_digits=0.
- Keys 4,5,SIGN,ENTER; i_ready=0 for 10 cycles -> o_val=0xFFFFFFD3 held with o_valid=1 for all 10 cycles; o_busy=1; a digit key pressed during HOLD leaves o_bcd unchanged.
- Nine 9s, then digit 1 -> error pulses for exactly 1 cycle, o_bcd=0x999999999, o_digits=9; ENTER -> o_val=0x3B9AC9FF.
- Keys 0,0,5,6,BKSP,7 -> o_digits=2, o_bcd=0x57; CLR -> o_bcd=0, o_digits=0, o_neg=0.
- SIGN,ENTER with no digits -> o_val=0x00000000, o_neg latched but result positive, error never asserted.
- Keys 8,ENTER, then RST_N low 20 cycles into CONV -> all outputs 0 immediately (before the next CLK edge); after release, no o_valid appears and 7,ENTER yields o_val=7.

Source files
------------

// File: rtl/key_entry_pkg.sv
// Shared key codes, default operand width and entry-FSM state encodings for the key_entry block.
package key_entry_pkg;

    localparam int unsigned OUTPUTWIDTH = 32;

    localparam logic [3:0] KEY_SIGN  = 4'hA;
    localparam logic [3:0] KEY_CLR   = 4'hB;
    localparam logic [3:0] KEY_BKSP  = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hD;

    localparam logic [1:0] StEntry = 2'd0;
    localparam logic [1:0] StConv  = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_entry_bcd_to_bin.sv
// Reverse double-dabble core: i_ce captures a signed BCD operand, one shift per cycle follows,
// and done pulses for one cycle once o_val holds the two's-complement result.
module bcd_to_bin
    import key_entry_pkg::*;
#(
    parameter int unsigned M         = OUTPUTWIDTH,
    parameter int unsigned BCD_WIDTH = 36
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 i_ce,
    input  logic [BCD_WIDTH-1:0] i_bcd,
    input  logic                 i_neg,
    output logic [M-1:0]         o_val,
    output logic                 done
);

    localparam int unsigned CntW = $clog2(BCD_WIDTH + 1);
    localparam int unsigned MagW = (M - 1 < BCD_WIDTH) ? M - 1 : BCD_WIDTH;

    logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
    logic [BCD_WIDTH-1:0] bin_q;
    logic                 neg_q;
    logic [CntW-1:0]      cnt_q;
    logic                 run_q;
    logic                 done_q;
    logic [M-1:0]         mag;

    // Shift right, then pull every digit that crossed into the upper half back by 3.
    always_comb begin
        bcd_d = bcd_q >> 1;
        for (int g = 0; g < int'(BCD_WIDTH / 4); g++) begin
            if (bcd_d[4*g +: 4] >= 4'd8) begin
                bcd_d[4*g +: 4] = bcd_d[4*g +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (i_ce) begin
            bcd_q  <= i_bcd;
            bin_q  <= '0;
            neg_q  <= i_neg;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            bin_q <= {bcd_q[0], bin_q[BCD_WIDTH-1:1]};
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(BCD_WIDTH - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    always_comb begin
        mag             = '0;
        mag[MagW-1:0]   = bin_q[MagW-1:0];
        o_val           = (neg_q && (mag != '0)) ? -mag : mag;
    end

    assign done = done_q;

endmodule

// File: rtl/key_entry.sv
// Keypad operand entry: builds a signed BCD operand from key strobes, converts it to binary
// and offers the result through a valid/ready handshake.
module key_entry
    import key_entry_pkg::*;
#(
    parameter int unsigned M          = OUTPUTWIDTH,
    parameter int unsigned MAX_DIGITS = 9,
    parameter int unsigned BCD_WIDTH  = 4 * MAX_DIGITS
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    input  logic                 i_ready,
    output logic [M-1:0]         o_val,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic [BCD_WIDTH-1:0] o_bcd,
    output logic [3:0]           o_digits,
    output logic                 o_neg,
    output logic                 error
);

    logic [1:0]           state_q, state_d;
    logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [M-1:0]         val_q, val_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic                 conv_start;
    logic                 conv_done;
    logic [M-1:0]         conv_val;

    bcd_to_bin #(
        .M         (M),
        .BCD_WIDTH (BCD_WIDTH)
    ) u_bcd_to_bin (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_ce  (conv_start),
        .i_bcd (bcd_q),
        .i_neg (neg_q),
        .o_val (conv_val),
        .done  (conv_done)
    );

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        val_d      = val_q;
        valid_d    = valid_q;
        error_d    = 1'b0;
        conv_start = 1'b0;
        case (state_q)
            StEntry: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        // Leading zeros are never stored.
                        if (!(cnt_q == 4'd0 && key_code == 4'd0)) begin
                            if (cnt_q < 4'(MAX_DIGITS)) begin
                                bcd_d = {bcd_q[BCD_WIDTH-5:0], key_code};
                                cnt_d = cnt_q + 4'd1;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end else begin
                        case (key_code)
                            KEY_SIGN: neg_d = ~neg_q;
                            KEY_BKSP: begin
                                if (cnt_q != 4'd0) begin
                                    bcd_d = bcd_q >> 4;
                                    cnt_d = cnt_q - 4'd1;
                                end
                            end
                            KEY_CLR: begin
                                bcd_d = '0;
                                cnt_d = 4'd0;
                                neg_d = 1'b0;
                            end
                            KEY_ENTER: begin
                                conv_start = 1'b1;
                                state_d    = StConv;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            StConv: begin
                if (conv_done) begin
                    val_d   = conv_val;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = StEntry;
                    bcd_d   = '0;
                    cnt_d   = 4'd0;
                    neg_d   = 1'b0;
                end
            end
            default: state_d = StEntry;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StEntry;
            bcd_q   <= '0;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
            val_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign o_val    = val_q;
    assign o_valid  = valid_q;
    assign o_busy   = (state_q != StEntry);
    assign o_bcd    = bcd_q;
    assign o_digits = cnt_q;
    assign o_neg    = neg_q;
    assign error    = error_q;

endmodule
